// File: rtl/axis_input_slice_pkg.sv
// Shared types for the conv-engine input slice: opaque tuser layout and the
// observable slice occupancy states.
package axis_input_slice_pkg;

    typedef struct packed {
        logic [7:0] layer_cfg;
        logic [3:0] kernel_id;
        logic [1:0] mode;
        logic       start_frame;
        logic       end_row;
    } tuser_st;

    localparam int unsigned TUSER_ST_WIDTH = $bits(tuser_st);

    // Encoding matches {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } slice_state_t;

    function automatic int unsigned payload_width(
        input int unsigned rows,
        input int unsigned cols,
        input int unsigned word_width,
        input int unsigned tuser_width
    );
        return word_width * (rows + cols) + tuser_width + 1;
    endfunction

endpackage

// File: rtl/axis_input_slice_if.sv
// Joined pixel/weight AXI-Stream beat: one valid/ready pair shared by both
// data vectors plus tlast and tuser.
interface axis_input_slice_if
    import axis_input_slice_pkg::*;
#(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned COLS        = 24,
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned TUSER_WIDTH = TUSER_ST_WIDTH
);

    logic                         tvalid;
    logic                         tready;
    logic                         tlast;
    logic [TUSER_WIDTH-1:0]       tuser;
    logic [WORD_WIDTH*ROWS-1:0]   pixels_tdata;
    logic [WORD_WIDTH*COLS-1:0]   weights_tdata;

    modport master (
        output tvalid,
        output tlast,
        output tuser,
        output pixels_tdata,
        output weights_tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tuser,
        input  pixels_tdata,
        input  weights_tdata,
        output tready
    );

endinterface

// File: rtl/axis_skid_reg.sv
// Generic two-entry register slice: registered valid, data and ready, full
// throughput, strict FIFO order.
module axis_skid_reg
    import axis_input_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] skid_data_q;

    logic         in_hs;
    logic         out_hs;
    logic         main_load_in;
    logic         main_load_skid;
    logic         skid_load;
    slice_state_t state;

    assign state  = slice_state_t'({main_valid_q, skid_valid_q});
    assign in_hs  = in_valid & ready_q;
    assign out_hs = main_valid_q & out_ready;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    main_valid_d = 1'b1;
                    main_load_in = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    main_load_in = 1'b1;
                end else if (in_hs) begin
                    skid_valid_d = 1'b1;
                    skid_load    = 1'b1;
                end else if (out_hs) begin
                    main_valid_d = 1'b0;
                end
            end
            FULL: begin
                // ready is low here, so no input can arrive this cycle
                if (out_hs) begin
                    skid_valid_d   = 1'b0;
                    main_load_skid = 1'b1;
                end
            end
            default: begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
    end

    // Ready is a pure register of next-cycle skid occupancy; it stays low
    // through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (main_load_in) begin
            main_data_q <= in_data;
        end else if (main_load_skid) begin
            main_data_q <= skid_data_q;
        end
        if (skid_load) begin
            skid_data_q <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/axis_input_slice.sv
// Register slice between the pixel/weight sync stage and the conv engine,
// with output tuser/tlast masking and debug beat/packet counters.
module axis_input_slice
    import axis_input_slice_pkg::*;
#(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned COLS        = 24,
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned TUSER_WIDTH = TUSER_ST_WIDTH,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axis_input_slice_if.slave    s_axis,
    axis_input_slice_if.master   m_axis,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] packet_count
);

    localparam int unsigned PAYLOAD_WIDTH = payload_width(ROWS, COLS, WORD_WIDTH, TUSER_WIDTH);

    logic [PAYLOAD_WIDTH-1:0]   in_payload;
    logic [PAYLOAD_WIDTH-1:0]   out_payload;
    logic                       out_valid;
    logic                       out_hs;
    logic [WORD_WIDTH*ROWS-1:0] out_pixels;
    logic [WORD_WIDTH*COLS-1:0] out_weights;
    logic                       out_tlast;
    logic [TUSER_WIDTH-1:0]     out_tuser;

    logic [CNT_WIDTH-1:0] beat_count_q;
    logic [CNT_WIDTH-1:0] packet_count_q;

    assign in_payload = {s_axis.pixels_tdata, s_axis.weights_tdata, s_axis.tlast, s_axis.tuser};

    axis_skid_reg #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (s_axis.tvalid),
        .in_ready  (s_axis.tready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (m_axis.tready),
        .out_data  (out_payload)
    );

    assign {out_pixels, out_weights, out_tlast, out_tuser} = out_payload;

    // Payload registers are not reset, so sideband is masked while invalid.
    assign m_axis.tvalid        = out_valid;
    assign m_axis.tlast         = out_valid & out_tlast;
    assign m_axis.tuser         = out_valid ? out_tuser : '0;
    assign m_axis.pixels_tdata  = out_pixels;
    assign m_axis.weights_tdata = out_weights;

    assign out_hs = out_valid & m_axis.tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count_q   <= '0;
            packet_count_q <= '0;
        end else if (out_hs) begin
            beat_count_q <= beat_count_q + CNT_WIDTH'(1);
            if (out_tlast) begin
                packet_count_q <= packet_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign beat_count   = beat_count_q;
    assign packet_count = packet_count_q;

endmodule

// File: doc/axis_input_slice.md
Name: axis_input_slice

Overview:
- Full-bandwidth two-entry AXI-Stream register slice. Sits directly downstream of the pixel/weight synchronizing input stage and directly upstream of the conv engine.
- Carries one joined beat per handshake: pixels word vector, weights word vector, tlast and tuser.
- Registers all forward signals and the backward tready, which breaks the long combinational ready path from the engine into both input streams.
- Adds per-beat and per-packet counters for debug.

Parameters:
- ROWS, 8, pixel words per beat.
- COLS, 24, weight words per beat.
- WORD_WIDTH, 8, bits per word.
- TUSER_WIDTH, $bits(tuser_st), packed tuser width.
- CNT_WIDTH, 32, width of the debug counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tready  out  1  slice can accept a beat
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tlast  in  1  last beat of a weights packet
- s_axis_tuser  in  TUSER_WIDTH  packed tuser_st
- s_axis_pixels_tdata  in  WORD_WIDTH*ROWS  pixel words
- s_axis_weights_tdata  in  WORD_WIDTH*COLS  weight words
- m_axis_tready  in  1  engine ready
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  registered tlast
- m_axis_tuser  out  TUSER_WIDTH  registered tuser
- m_axis_pixels_tdata  out  WORD_WIDTH*ROWS  registered pixels
- m_axis_weights_tdata  out  WORD_WIDTH*COLS  registered weights
- beat_count  out  CNT_WIDTH  output handshakes since reset
- packet_count  out  CNT_WIDTH  output handshakes with tlast=1 since reset

Behaviour:
- Storage:
  - main register (drives m_*);
  - skid register; each holds {pixels, weights, tlast, tuser}.
  - State encoded by main_valid/skid_valid: EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) is illegal.
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid=0, s_axis_tready=0, beat_count=0, packet_count=0, state EMPTY.
  - Data/tuser/tlast registers are not reset; m_axis_tlast and m_axis_tuser are forced to 0 while m_axis_tvalid=0 (masked output).
  - s_axis_tready rises at the first aclk edge after aresetn deasserts.
- s_axis_tready: registered, equals !skid_valid after that first edge. It never depends combinationally on m_axis_tready or s_axis_tvalid.
- Handshakes: in_hs = s_axis_tvalid & s_axis_tready; out_hs = m_axis_tvalid & m_axis_tready.
- Transitions at the aclk edge:
  - EMPTY, in_hs → ONE; main captures input.
  - ONE:
    - in_hs & out_hs → ONE; main captures input.
    - in_hs & !out_hs → FULL; skid captures input, s_axis_tready falls.
    - !in_hs & out_hs → EMPTY.
  - FULL:
    - out_hs → ONE; main loads skid, s_axis_tready rises.
    - In_hs is impossible because ready=0.
- Latency: 1 cycle from in_hs to m_axis_tvalid when EMPTY. Throughput is 1 beat/cycle with continuous m_axis_tready.
- Ordering: strict FIFO; no beat dropped or duplicated.
- Held output: m_* stable while m_axis_tvalid & !m_axis_tready.
- tuser is opaque. Pulse-type fields are already qualified by valid upstream; the slice preserves them bit-exact with their beat.
- Counters:
  - beat_count += 1 on out_hs.
  - packet_count += 1 on out_hs & m_axis_tlast.
  - Both wrap modulo 2^CNT_WIDTH.
- Simultaneous in/out in ONE is legal every cycle.
- Reset mid-packet: all buffered beats are discarded and counters are cleared. Upstream restarts the packet.

Decomposition:
- Shared package holds:
  - tuser_st (already defined there), with TUSER_WIDTH derived from it;
  - a slice_state_t enum {EMPTY, ONE, FULL} for the bench and assertions.
- The payload is concatenated internally into a single vector of width WORD_WIDTH*(ROWS+COLS)+TUSER_WIDTH+1.
- One natural sub-module: axis_skid_reg. It is a generic width-parameterized two-entry slice on that vector. axis_input_slice instantiates it and adds the tuser/tlast masking and the counters.

Test Plan:
- Reset/idle: hold aresetn low 5 cycles → m_axis_tvalid=0, s_axis_tready=0, counters 0. First edge after release → s_axis_tready=1.
- Streaming: 100 beats, pixels word0=i, m_axis_tready=1 always → beats emerge 1 cycle after input in order. beat_count=100, s_axis_tready never drops.
- Backpressure: m_axis_tready=0 for 4 cycles with input valid → exactly 2 beats accepted, then s_axis_tready=0 and m_* held stable. On release, beats 0,1,2… emerge in order with no loss.
- Random valid/ready at 50% each, 10000 beats → scoreboard matches all fields.
  - tlast set every 9th beat → packet_count = floor(10000/9) = 1111.
  - Assertion: state never (0,1).
- Config/tuser integrity: alternate tuser patterns 0x5A5A and 0xA5A5 with tlast toggling → m_axis_tuser bit-exact per beat, 0 whenever m_axis_tvalid=0.
- Mid-operation reset: assert aresetn in FULL state → m_axis_tvalid=0 immediately (asynchronously). After release, only new beats appear and counters restart at 0.
